// File: rtl/hdmi_tmds_encoder.sv
// hdmi_tmds_encoder: per-channel TMDS symbol encoder for HDMI. Each cycle
// emits a control, video (8b/10b with DC balancing), guard-band or TERC4
// symbol on every channel, selected by the period type on mode_i.
module hdmi_tmds_encoder #(
    parameter int NUM_CH = 3,
    parameter int PIPE   = 1
) (
    input  logic                  clk,
    input  logic                  rstn_i,
    input  logic [2:0]            mode_i,
    input  logic [8*NUM_CH-1:0]   vd_i,
    input  logic [1:0]            cd_i,
    input  logic [3:0]            ctl_i,
    input  logic [4*NUM_CH-1:0]   aux_i,
    output logic [10*NUM_CH-1:0]  tmds_o,
    output logic                  mode_err_o
);

    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_VIDEO  = 3'd1;
    localparam logic [2:0] MODE_VGUARD = 3'd2;
    localparam logic [2:0] MODE_DATA   = 3'd3;
    localparam logic [2:0] MODE_DGUARD = 3'd4;

    function automatic logic [9:0] ctrl_code(input logic [1:0] b);
        case (b)
            2'b00:   ctrl_code = 10'b1101010100;
            2'b01:   ctrl_code = 10'b0010101011;
            2'b10:   ctrl_code = 10'b0101010100;
            default: ctrl_code = 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] terc4_code(input logic [3:0] n);
        case (n)
            4'h0:    terc4_code = 10'b1010011100;
            4'h1:    terc4_code = 10'b1001100011;
            4'h2:    terc4_code = 10'b1011100100;
            4'h3:    terc4_code = 10'b1011100010;
            4'h4:    terc4_code = 10'b0101110001;
            4'h5:    terc4_code = 10'b0100011110;
            4'h6:    terc4_code = 10'b0110001110;
            4'h7:    terc4_code = 10'b0100111100;
            4'h8:    terc4_code = 10'b1011001100;
            4'h9:    terc4_code = 10'b0100111001;
            4'hA:    terc4_code = 10'b0110011100;
            4'hB:    terc4_code = 10'b1011000110;
            4'hC:    terc4_code = 10'b1010001110;
            4'hD:    terc4_code = 10'b1001110001;
            4'hE:    terc4_code = 10'b0101100011;
            default: terc4_code = 10'b1011000011;
        endcase
    endfunction

    function automatic logic [3:0] ones8(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
        return n;
    endfunction

    // Transition-minimising first stage; q_m[8] records XOR (1) vs XNOR (0).
    function automatic logic [8:0] min_trans(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] qm;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        qm       = 9'd0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8]    = ~use_xnor;
        return qm;
    endfunction

    logic [2:0]          mode_p0;
    logic [8*NUM_CH-1:0] vd_p0;
    logic [1:0]          cd_p0;
    logic [3:0]          ctl_p0;
    logic [4*NUM_CH-1:0] aux_p0;
    logic                mode_illegal;

    // ---- stage p0: encoder inputs (registered when PIPE == 2) ----
    if (PIPE == 2) begin : g_in_reg
        // Input register; its reset contents decode as control 00.
        always_ff @(posedge clk or negedge rstn_i) begin
            if (!rstn_i) begin
                mode_p0 <= '0;
                vd_p0   <= '0;
                cd_p0   <= '0;
                ctl_p0  <= '0;
                aux_p0  <= '0;
            end else begin
                mode_p0 <= mode_i;
                vd_p0   <= vd_i;
                cd_p0   <= cd_i;
                ctl_p0  <= ctl_i;
                aux_p0  <= aux_i;
            end
        end
    end else begin : g_in_pass
        // Single-cycle latency: encode directly from the ports.
        always_comb begin
            mode_p0 = mode_i;
            vd_p0   = vd_i;
            cd_p0   = cd_i;
            ctl_p0  = ctl_i;
            aux_p0  = aux_i;
        end
    end

    assign mode_illegal = (mode_p0 > MODE_DGUARD);

    // Sticky error, set on the edge that registers an illegal-mode symbol.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i)           mode_err_o <= 1'b0;
        else if (mode_illegal) mode_err_o <= 1'b1;
    end

    // ---- stage p1: per-channel symbol and disparity registers ----
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]        ctl_bits;
        logic [8:0]        qm;
        logic signed [5:0] n1;
        logic signed [5:0] n0;
        logic              inv;
        logic [9:0]        sym_nx;
        logic signed [5:0] cnt_nx;
        logic [9:0]        sym_p1;
        logic signed [5:0] cnt_p1;

        if (c == 0) begin : g_b0
            assign ctl_bits = cd_p0;
        end else if (c == 1) begin : g_b1
            assign ctl_bits = ctl_p0[1:0];
        end else if (c == 2) begin : g_b2
            assign ctl_bits = ctl_p0[3:2];
        end else begin : g_bx
            assign ctl_bits = 2'b00;
        end

        // Symbol select; disparity falls back to zero outside video.
        always_comb begin
            qm     = min_trans(vd_p0[8*c +: 8]);
            n1     = $signed({2'b00, ones8(qm[7:0])});
            n0     = 6'sd8 - n1;
            inv    = 1'b0;
            cnt_nx = 6'sd0;
            sym_nx = ctrl_code(ctl_bits);
            case (mode_p0)
                MODE_VIDEO: begin
                    if ((cnt_p1 == 6'sd0) || (n1 == n0)) begin
                        inv    = ~qm[8];
                        cnt_nx = qm[8] ? (cnt_p1 + n1 - n0) : (cnt_p1 + n0 - n1);
                    end else if (((cnt_p1 > 6'sd0) && (n1 > n0)) ||
                                 ((cnt_p1 < 6'sd0) && (n0 > n1))) begin
                        inv    = 1'b1;
                        cnt_nx = cnt_p1 + (qm[8] ? 6'sd2 : 6'sd0) + n0 - n1;
                    end else begin
                        inv    = 1'b0;
                        cnt_nx = cnt_p1 + n1 - n0 - (qm[8] ? 6'sd0 : 6'sd2);
                    end
                    sym_nx = {inv, qm[8], qm[7:0] ^ {8{inv}}};
                end
                MODE_VGUARD: sym_nx = (c == 1) ? 10'b0100110011 : 10'b1011001100;
                MODE_DATA:   sym_nx = terc4_code(aux_p0[4*c +: 4]);
                MODE_DGUARD: sym_nx = (c == 0) ? terc4_code({2'b11, cd_p0}) : 10'b0100110011;
                MODE_CTRL:   sym_nx = ctrl_code(ctl_bits);
                default:     sym_nx = ctrl_code(ctl_bits);
            endcase
        end

        // Symbol and running disparity advance together.
        always_ff @(posedge clk or negedge rstn_i) begin
            if (!rstn_i) begin
                sym_p1 <= '0;
                cnt_p1 <= '0;
            end else begin
                sym_p1 <= sym_nx;
                cnt_p1 <= cnt_nx;
            end
        end

        assign tmds_o[10*c +: 10] = sym_p1;
    end

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Bench for hdmi_tmds_encoder: a 3-channel PIPE=1 instance and a 4-channel
// PIPE=2 instance share stimulus; a scoreboard checks both against a model.
module tb_hdmi_tmds_encoder;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic [2:0]  mode_i;
    logic [31:0] vd_i;
    logic [1:0]  cd_i;
    logic [3:0]  ctl_i;
    logic [15:0] aux_i;
    logic [29:0] tmds_a;
    logic        err_a;
    logic [39:0] tmds_b;
    logic        err_b;

    hdmi_tmds_encoder #(.NUM_CH(3), .PIPE(1)) dut_a (
        .clk(clk), .rstn_i(rstn_i), .mode_i(mode_i), .vd_i(vd_i[23:0]),
        .cd_i(cd_i), .ctl_i(ctl_i), .aux_i(aux_i[11:0]),
        .tmds_o(tmds_a), .mode_err_o(err_a)
    );

    hdmi_tmds_encoder #(.NUM_CH(4), .PIPE(2)) dut_b (
        .clk(clk), .rstn_i(rstn_i), .mode_i(mode_i), .vd_i(vd_i),
        .cd_i(cd_i), .ctl_i(ctl_i), .aux_i(aux_i),
        .tmds_o(tmds_b), .mode_err_o(err_b)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] TERC4 [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;

    typedef struct {
        logic [39:0] sym;
        logic        err;
        int          due;
        logic        has_k;
        logic [19:0] k;
        logic        kerr;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    int   ref_cnt [4];
    logic ref_err;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [9:0] ref_ctrl(input logic [1:0] b);
        case (b)
            2'b00:   return C00;
            2'b01:   return C01;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Video 8b/10b from the encoding rules, disparity kept as an int.
    function automatic logic [9:0] ref_video(input int ch, input logic [7:0] d);
        int         ones_d, n1, n0;
        bit         xn, inv;
        logic [8:0] qm;
        ones_d = $countones(d);
        xn     = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
        qm[0]  = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8]  = !xn;
        n1     = $countones(qm[7:0]);
        n0     = 8 - n1;
        if (ref_cnt[ch] == 0 || n1 == n0) begin
            inv = !qm[8];
            ref_cnt[ch] += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((ref_cnt[ch] > 0 && n1 > n0) || (ref_cnt[ch] < 0 && n0 > n1)) begin
            inv = 1'b1;
            ref_cnt[ch] += (qm[8] ? 2 : 0) + n0 - n1;
        end else begin
            inv = 1'b0;
            ref_cnt[ch] += n1 - n0 - (qm[8] ? 0 : 2);
        end
        return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    endfunction

    function automatic logic [39:0] ref_symbols(input logic [2:0] m, input logic [31:0] vd,
                                                input logic [1:0] cd, input logic [3:0] ctl,
                                                input logic [15:0] aux);
        logic [39:0] o;
        logic [9:0]  s;
        logic [1:0]  b;
        for (int ch = 0; ch < 4; ch++) begin
            b = (ch == 0) ? cd : (ch == 1) ? ctl[1:0] : (ch == 2) ? ctl[3:2] : 2'b00;
            case (m)
                3'd1:    s = ref_video(ch, vd[8*ch +: 8]);
                3'd2:    s = (ch == 1) ? 10'b0100110011 : 10'b1011001100;
                3'd3:    s = TERC4[aux[4*ch +: 4]];
                3'd4:    s = (ch == 0) ? TERC4[{2'b11, cd}] : 10'b0100110011;
                default: s = ref_ctrl(b);
            endcase
            if (m != 3'd1) ref_cnt[ch] = 0;
            o[10*ch +: 10] = s;
        end
        if (m > 3'd4) ref_err = 1'b1;
        return o;
    endfunction

    task automatic push_current(input logic has_k, input logic [19:0] k, input logic kerr);
        exp_t e;
        e.sym   = ref_symbols(mode_i, vd_i, cd_i, ctl_i, aux_i);
        e.err   = ref_err;
        e.has_k = has_k;
        e.k     = k;
        e.kerr  = kerr;
        e.due   = cyc + 1;
        qa.push_back(e);
        e.due   = cyc + 2;
        qb.push_back(e);
    endtask

    task automatic drive(input logic [2:0] m, input logic [31:0] vd, input logic [1:0] cd,
                         input logic [3:0] ctl, input logic [15:0] aux,
                         input logic has_k = 1'b0, input logic [19:0] k = 20'd0,
                         input logic kerr = 1'b0);
        @(negedge clk);
        mode_i = m;
        vd_i   = vd;
        cd_i   = cd;
        ctl_i  = ctl;
        aux_i  = aux;
        push_current(has_k, k, kerr);
    endtask

    // Assert reset between edges, confirm it clears at once, release in control 00.
    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        #2;
        rstn_i = 1'b0;
        qa.delete();
        qb.delete();
        for (int ch = 0; ch < 4; ch++) ref_cnt[ch] = 0;
        ref_err = 1'b0;
        #1;
        check("async_rst_tmds_a", {10'd0, tmds_a}, 40'd0);
        check("async_rst_tmds_b", tmds_b, 40'd0);
        check("async_rst_err", {38'd0, err_a, err_b}, 40'd0);
        repeat (3) @(negedge clk);
        mode_i = 3'd0;
        vd_i   = '0;
        cd_i   = 2'b00;
        ctl_i  = 4'b0000;
        aux_i  = '0;
        rstn_i = 1'b1;
        e.sym   = {C00, C00, C00, C00};
        e.err   = 1'b0;
        e.has_k = 1'b1;
        e.k     = {C00, C00};
        e.kerr  = 1'b0;
        e.due   = cyc + 1;
        qb.push_back(e);
        push_current(1'b1, {C00, C00}, 1'b0);
    endtask

    // Monitor: after each edge, retire whatever is due on each instance.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #2;
            if (!rstn_i) begin
                check("rst_tmds_a", {10'd0, tmds_a}, 40'd0);
                check("rst_tmds_b", tmds_b, 40'd0);
                check("rst_err", {38'd0, err_a, err_b}, 40'd0);
            end else begin
                while (qa.size() > 0 && qa[0].due < cyc) begin
                    tests++; fails++;
                    $display("FAIL late_a: entry due %0d, now %0d", qa[0].due, cyc);
                    void'(qa.pop_front());
                end
                while (qb.size() > 0 && qb[0].due < cyc) begin
                    tests++; fails++;
                    $display("FAIL late_b: entry due %0d, now %0d", qb[0].due, cyc);
                    void'(qb.pop_front());
                end
                if (qa.size() > 0 && qa[0].due == cyc) begin
                    e = qa.pop_front();
                    check("sym_a", {10'd0, tmds_a}, {10'd0, e.sym[29:0]});
                    check("err_a", {39'd0, err_a}, {39'd0, e.err});
                    if (e.has_k) begin
                        check("known_sym_a", {20'd0, tmds_a[19:0]}, {20'd0, e.k});
                        check("known_err_a", {39'd0, err_a}, {39'd0, e.kerr});
                    end
                end
                if (qb.size() > 0 && qb[0].due == cyc) begin
                    e = qb.pop_front();
                    check("sym_b", tmds_b, e.sym);
                    check("err_b", {39'd0, err_b}, {39'd0, e.err});
                    if (e.has_k) begin
                        check("known_sym_b", {20'd0, tmds_b[19:0]}, {20'd0, e.k});
                        check("known_err_b", {39'd0, err_b}, {39'd0, e.kerr});
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          r;
        logic [2:0]  m;
        rstn_i  = 1'b1;
        mode_i  = '0;
        vd_i    = '0;
        cd_i    = '0;
        ctl_i   = '0;
        aux_i   = '0;
        ref_err = 1'b0;
        for (int ch = 0; ch < 4; ch++) ref_cnt[ch] = 0;
        #1 rstn_i = 1'b0;

        // Reset and control-period outputs
        do_reset();
        drive(3'd0, 32'd0, 2'b00, 4'b0000, 16'd0, 1'b1, {C00, C00}, 1'b0);
        drive(3'd0, 32'd0, 2'b01, 4'b0001, 16'd0, 1'b1, {C01, C01}, 1'b0);

        // Video zeros from cnt=0: disparity -8, 2, -6, 4
        drive(3'd1, 32'd0, 2'b00, 4'b0000, 16'd0, 1'b1, {2{10'b0100000000}}, 1'b0);
        drive(3'd1, 32'd0, 2'b00, 4'b0000, 16'd0, 1'b1, {2{10'b1111111111}}, 1'b0);
        drive(3'd1, 32'd0, 2'b00, 4'b0000, 16'd0, 1'b1, {2{10'b0100000000}}, 1'b0);
        drive(3'd1, 32'd0, 2'b00, 4'b0000, 16'd0, 1'b1, {2{10'b1111111111}}, 1'b0);

        // Video guard band clears disparity
        drive(3'd2, 32'd0, 2'b00, 4'b0000, 16'd0, 1'b1, {10'b0100110011, 10'b1011001100}, 1'b0);
        drive(3'd1, 32'd0, 2'b00, 4'b0000, 16'd0, 1'b1, {2{10'b0100000000}}, 1'b0);

        // Data island and its guard band
        drive(3'd3, 32'd0, 2'b00, 4'b0000, 16'h00F5, 1'b1, {10'b1011000011, 10'b0100011110}, 1'b0);
        drive(3'd4, 32'd0, 2'b10, 4'b0000, 16'h00F5, 1'b1, {10'b0100110011, 10'b0101100011}, 1'b0);

        // Reset in the middle of a video run
        for (int i = 0; i < 5; i++) drive(3'd1, $urandom, 2'b00, 4'b0000, 16'd0);
        do_reset();
        drive(3'd1, 32'd0, 2'b00, 4'b0000, 16'd0, 1'b1, {2{10'b0100000000}}, 1'b0);

        // Illegal mode: encodes as control, error stays set
        drive(3'd7, 32'd0, 2'b01, 4'b0001, 16'd0, 1'b1, {C01, C01}, 1'b1);
        for (int i = 0; i < 3; i++)
            drive(3'd0, 32'd0, 2'b00, 4'b0000, 16'd0, 1'b1, {C00, C00}, 1'b1);
        do_reset();

        // Randomised traffic, mostly video
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                do_reset();
            end else begin
                if (r < 3)       m = 3'($urandom_range(5, 7));
                else if (r < 60) m = 3'd1;
                else             m = 3'($urandom_range(0, 4));
                drive(m, $urandom, 2'($urandom), 4'($urandom), 16'($urandom));
            end
        end

        repeat (4) @(negedge clk);
        check("drain_a", 40'(qa.size()), 40'd0);
        check("drain_b", 40'(qb.size()), 40'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
